muldiv_ctrl: RTL
================

// Module: muldiv_ctrl
// PURPOSE
//  Iterative multiply/divide controller, HI/LO owner, for the 5-stage MIPS pipeline, sitting beside the EX-stage ALU.
//  Accepts mult/multu/div/divu, runs a radix-2 shift-add or restoring-divide sequence, and writes HI/LO.
//  Serves mfhi/mflo/mthi/mtlo and raises a pipeline stall while a HI/LO consumer or a new muldiv op meets a busy unit.
// PARAMETERS
//  W      32  operand/HI/LO width
//  CNT_W  6   iteration counter width; holds 0..W
// PORTS
//  clk      in   1  clock, rising edge
//  rst      in   1  reset; asynchronous, active-low
//  issue    in   1  R-type instr valid in EX this cycle (not flushed)
//  func     in   6  funct field of the EX instr
//  rs_data  in   W  forwarded rs value: multiplicand/dividend; mthi/mtlo source
//  rt_data  in   W  forwarded rt value: multiplier/divisor
//  stall    out  1  freeze IF/ID/EX, bubble into MEM (combinational)
//  busy     out  1  sequence in progress (registered)
//  done     out  1  one-cycle pulse: HI/LO just updated by a muldiv op
//  hi       out  W  HI register
//  lo       out  W  LO register
//  mf_data  out  W  mfhi -> hi, mflo -> lo, else 0 (combinational)
// BEHAVIOUR
//  - Reset (rst=0, any time, incl. mid-op): state=IDLE, busy=0, done=0, hi=lo=0, counter=0; the in-flight op is discarded.
//  - funct codes: mult 011000, multu 011001, div 011010, divu 011011, mfhi 010000, mthi 010001, mflo 010010, mtlo 010011.
//  - stall = issue & (func is any of the 8 above) & busy. No stall when busy=0.
//  - FSM IDLE -> RUN -> FIX -> IDLE.
//    IDLE: issue & muldiv & !busy -> latch |rs|,|rt| (signed ops take magnitudes and record result signs), cnt=0, go RUN.
//      mthi/mtlo in IDLE: write hi/lo at the clock edge.
//    RUN: one bit per cycle; cnt++; at cnt==W-1 go FIX. Inputs ignored; stall covers any HI/LO user.
//    FIX: apply sign correction, write {hi,lo} at the end of the cycle, go IDLE.
//  - busy=1 in RUN and FIX. Latency: accepted at edge E0, hi/lo valid after edge E0+W+1 (33 cycles at W=32).
//    done=1 in the first IDLE cycle after FIX.
//  - A new op issued in that first IDLE cycle is accepted (back-to-back, no gap). A stalled op issues the cycle busy falls.
//  - mult/multu: {hi,lo} = 2W-bit product; signed result negated if operand signs differ.
//  - div/divu: lo = quotient, hi = remainder; truncate toward zero; remainder takes dividend sign.
//  - Divide by zero: lo = all-ones, hi = dividend (raw rs). Takes full latency, never hangs.
//  - div INT_MIN / -1: lo = 0x80000000, hi = 0 (wraps, no trap).
//  - Flush never cancels an accepted op; only issue gates acceptance.
// CONFIGURATION
//  MULDIV_EARLY_OUT_EN defined: a multiply in RUN goes to FIX the cycle after the remaining multiplier shift register is 0.
//    Latency ranges 2..W+1. done/busy timing follows the actual FIX cycle. Divide latency is unchanged.
//  Not defined: every op takes exactly W+1 cycles.
// STRUCTURE
//  Shared package mips_pkg: funct localparams (FN_MULT..FN_MTLO), state encoding (MD_IDLE/MD_RUN/MD_FIX),
//    existing opcode/ALU-op constants.
//  Sub-module muldiv_iter: accumulator/shift registers and add/sub step, with load/step/fix controls.
//  muldiv_ctrl holds the FSM, counter, sign bookkeeping, stall, HI/LO and mf mux.
// TESTING
//  1. mult 7 x 0xFFFFFFFD (-3) -> after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFEB, done pulse 1 cycle.
//  2. multu 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
//  3. div 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//     divu 100/7 -> lo=14, hi=2.
//     div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
//  4. divu 5/0 -> lo=0xFFFFFFFF, hi=5 at cycle 33, busy drops.
//  5. mult, then mflo issued next cycle -> stall=1 until busy falls, then mf_data = new lo.
//     mthi 0x1234 while idle -> hi=0x1234 next cycle.
//  6. rst low at cycle 10 of a mult -> busy=0, hi=lo=0 immediately; then mult 3x4 -> lo=12.
//     With MULDIV_EARLY_OUT_EN, mult 5x1 completes in 2 cycles.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcode/ALU constants, muldiv funct codes,
// muldiv FSM state encoding and small funct-decode helpers.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLT = 4'd5,
        ALU_SLL = 4'd6,
        ALU_SRL = 4'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2
    } md_state_t;

    // mult/multu/div/divu share funct[5:2] = 0110
    function automatic logic is_muldiv_fn(input logic [5:0] fn);
        return (fn[5:2] == 4'b0110);
    endfunction

    // mfhi/mthi/mflo/mtlo share funct[5:2] = 0100
    function automatic logic is_hilo_fn(input logic [5:0] fn);
        return (fn[5:2] == 4'b0100);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Radix-2 datapath for the muldiv unit: shift-add multiply (left-shifting
// multiplicand) and restoring divide, plus combinational sign-corrected results.
module muldiv_iter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         step,
    input  logic         is_div,
    input  logic [W-1:0] a_mag,
    input  logic [W-1:0] b_mag,
    input  logic         neg_lo,
    input  logic         neg_hi,
    input  logic         div_zero,
    output logic         mplier_last,
    output logic [W-1:0] res_hi,
    output logic [W-1:0] res_lo
);

    // acc_r: product (mult) or partial remainder in low W bits (div)
    // mc_r : shifted multiplicand (mult) or divisor in low W bits (div)
    // sh_r : remaining multiplier (mult) or dividend-in/quotient-out (div)
    logic [2*W-1:0] acc_r, acc_nx_s;
    logic [2*W-1:0] mc_r, mc_nx_s;
    logic [W-1:0]   sh_r, sh_nx_s;
    logic [W:0]     rem_sh_s;
    logic [W+1:0]   diff_s;
    logic [2*W-1:0] prod_s;

    // Next-state for load and one iteration step
    always_comb begin
        acc_nx_s = acc_r;
        mc_nx_s  = mc_r;
        sh_nx_s  = sh_r;
        rem_sh_s = {acc_r[W-1:0], sh_r[W-1]};
        diff_s   = {1'b0, rem_sh_s} - {2'b00, mc_r[W-1:0]};
        if (load) begin
            acc_nx_s = {(2*W){1'b0}};
            mc_nx_s  = {{W{1'b0}}, (is_div ? b_mag : a_mag)};
            sh_nx_s  = is_div ? a_mag : b_mag;
        end else if (step) begin
            if (is_div) begin
                // borrow means the trial subtraction failed: restore
                if (diff_s[W+1]) begin
                    acc_nx_s = {{W{1'b0}}, rem_sh_s[W-1:0]};
                    sh_nx_s  = {sh_r[W-2:0], 1'b0};
                end else begin
                    acc_nx_s = {{W{1'b0}}, diff_s[W-1:0]};
                    sh_nx_s  = {sh_r[W-2:0], 1'b1};
                end
            end else begin
                acc_nx_s = sh_r[0] ? (acc_r + mc_r) : acc_r;
                mc_nx_s  = {mc_r[2*W-2:0], 1'b0};
                sh_nx_s  = {1'b0, sh_r[W-1:1]};
            end
        end else begin
            acc_nx_s = acc_r;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_r <= {(2*W){1'b0}};
            mc_r  <= {(2*W){1'b0}};
            sh_r  <= {W{1'b0}};
        end else begin
            acc_r <= acc_nx_s;
            mc_r  <= mc_nx_s;
            sh_r  <= sh_nx_s;
        end
    end

    assign mplier_last = (sh_r[W-1:1] == {(W-1){1'b0}});

    // Sign correction; divide by zero forces an all-ones quotient
    always_comb begin
        prod_s = neg_lo ? ({(2*W){1'b0}} - acc_r) : acc_r;
        if (is_div) begin
            res_lo = div_zero ? {W{1'b1}} : (neg_lo ? ({W{1'b0}} - sh_r) : sh_r);
            res_hi = neg_hi ? ({W{1'b0}} - acc_r[W-1:0]) : acc_r[W-1:0];
        end else begin
            res_hi = prod_s[2*W-1:W];
            res_lo = prod_s[W-1:0];
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative multiply/divide controller and HI/LO owner beside the EX-stage ALU.
// Optional feature: define MULDIV_EARLY_OUT_EN for multiply early termination.
module muldiv_ctrl
    import mips_pkg::*;
#(
    parameter int W     = 32,
    parameter int CNT_W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         issue,
    input  logic [5:0]   func,
    input  logic [W-1:0] rs_data,
    input  logic [W-1:0] rt_data,
    output logic         stall,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic [W-1:0] mf_data
);

    md_state_t      state_r, next_s;
    logic [CNT_W-1:0] cnt_r;
    logic           busy_r, done_r;
    logic [W-1:0]   hi_r, lo_r;
    logic           is_div_r, neg_lo_r, neg_hi_r, dz_r;
    logic           is_md_s, is_hl_s, accept_s, signed_op_s, rs_neg_s, rt_neg_s;
    logic           load_s, step_s, wr_res_s, early_s, iter_div_s, mplier_last_s;
    logic [W-1:0]   a_mag_s, b_mag_s, res_hi_s, res_lo_s;

    function automatic logic [W-1:0] mag_f(input logic [W-1:0] v, input logic neg);
        return neg ? ({W{1'b0}} - v) : v;
    endfunction

    assign is_md_s     = is_muldiv_fn(func);
    assign is_hl_s     = is_hilo_fn(func);
    assign stall       = issue & (is_md_s | is_hl_s) & busy_r;
    assign accept_s    = issue & is_md_s & ~busy_r & (state_r == MD_IDLE);
    assign signed_op_s = ~func[0];
    assign rs_neg_s    = signed_op_s & rs_data[W-1];
    assign rt_neg_s    = signed_op_s & rt_data[W-1];
    assign a_mag_s     = mag_f(rs_data, rs_neg_s);
    assign b_mag_s     = mag_f(rt_data, rt_neg_s);
    assign iter_div_s  = accept_s ? func[1] : is_div_r;

`ifdef MULDIV_EARLY_OUT_EN
    assign early_s = ~is_div_r & mplier_last_s;
`else
    logic mplier_unused_s;
    assign mplier_unused_s = mplier_last_s;
    assign early_s         = 1'b0;
`endif

    muldiv_iter #(.W(W)) u_iter (
        .clk         (clk),
        .rst         (rst),
        .load        (load_s),
        .step        (step_s),
        .is_div      (iter_div_s),
        .a_mag       (a_mag_s),
        .b_mag       (b_mag_s),
        .neg_lo      (neg_lo_r),
        .neg_hi      (neg_hi_r),
        .div_zero    (dz_r),
        .mplier_last (mplier_last_s),
        .res_hi      (res_hi_s),
        .res_lo      (res_lo_s)
    );

    // FSM next state and datapath controls
    always_comb begin
        next_s   = state_r;
        load_s   = 1'b0;
        step_s   = 1'b0;
        wr_res_s = 1'b0;
        case (state_r)
            MD_IDLE: begin
                if (accept_s) begin
                    next_s = MD_RUN;
                    load_s = 1'b1;
                end else begin
                    next_s = MD_IDLE;
                end
            end
            MD_RUN: begin
                step_s = 1'b1;
                if ((cnt_r == CNT_W'(W-1)) || early_s) begin
                    next_s = MD_FIX;
                end else begin
                    next_s = MD_RUN;
                end
            end
            MD_FIX: begin
                wr_res_s = 1'b1;
                next_s   = MD_IDLE;
            end
            default: begin
                next_s = MD_IDLE;
            end
        endcase
    end

    // State, counter, status flags and latched operand signs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= MD_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            is_div_r <= 1'b0;
            neg_lo_r <= 1'b0;
            neg_hi_r <= 1'b0;
            dz_r     <= 1'b0;
        end else begin
            state_r <= next_s;
            busy_r  <= (next_s != MD_IDLE);
            done_r  <= wr_res_s;
            if (load_s || wr_res_s) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (step_s) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            if (load_s) begin
                is_div_r <= func[1];
                neg_lo_r <= rs_neg_s ^ rt_neg_s;
                neg_hi_r <= rs_neg_s;
                dz_r     <= (rt_data == {W{1'b0}});
            end
        end
    end

    // HI/LO: muldiv result at end of FIX, mthi/mtlo only while idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_r <= {W{1'b0}};
            lo_r <= {W{1'b0}};
        end else if (wr_res_s) begin
            hi_r <= res_hi_s;
            lo_r <= res_lo_s;
        end else if (issue && !busy_r && (func == FN_MTHI)) begin
            hi_r <= rs_data;
        end else if (issue && !busy_r && (func == FN_MTLO)) begin
            lo_r <= rs_data;
        end
    end

    // mfhi/mflo read mux
    always_comb begin
        if (func == FN_MFHI) begin
            mf_data = hi_r;
        end else if (func == FN_MFLO) begin
            mf_data = lo_r;
        end else begin
            mf_data = {W{1'b0}};
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule
